// File: rtl/uart2vga_pkg.sv
// Shared constants and FSM state type for the UART-to-VGA row loader.
package uart2vga_pkg;

  localparam int unsigned ByteSizeRowDef   = 240;
  localparam int unsigned HeightDef        = 480;
  localparam logic [7:0]  StopByteDef      = 8'hDD;
  localparam logic [7:0]  AnswerCodeDef    = 8'hAA;
  localparam logic [7:0]  SuccessDef       = 8'hFF;
  localparam logic [7:0]  NotAllDef        = 8'h11;
  localparam int unsigned TimeoutCyclesDef = 500_000;

  // Frame-buffer address width; 479*240+239 = 115199 fits in 17 bits.
  localparam int unsigned AddrW = 17;

  typedef enum logic [1:0] {
    StYHi,
    StYLo,
    StData,
    StStop
  } state_e;

endpackage

// File: rtl/uart_answer_queue.sv
// Single-entry answer holding register feeding the UART transmitter.
module uart_answer_queue (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       ovf
);

  logic       full_q, full_d;
  logic [7:0] data_q, data_d;
  logic       start_q, start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       ovf_q, ovf_d;
  logic       launch;

  // Launch when holding a byte and the transmitter is idle; skip the clock right after a
  // launch so a transmitter that raises busy one clock late is never double-started.
  always_comb begin
    launch    = full_q && !tx_busy && !start_q;
    full_d    = full_q;
    data_d    = data_q;
    start_d   = launch;
    tx_data_d = launch ? data_q : tx_data_q;
    ovf_d     = ovf_q;
    if (launch) begin
      full_d = 1'b0;
    end
    if (push) begin
      full_d = 1'b1;
      data_d = push_data;
      // A byte pushed while the entry drains in the same clock is not an overflow.
      if (full_q && !launch) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Queue state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 1'b0;
      data_q    <= 8'h00;
      start_q   <= 1'b0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      data_q    <= data_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx_start = start_q;
  assign tx_data  = tx_data_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/uart_row_loader.sv
// Receives framed pixel rows over UART (Y hi, Y lo, payload, stop byte), writes them to
// the frame buffer and answers every byte through a single-entry answer queue.
module uart_row_loader
  import uart2vga_pkg::*;
#(
  parameter int unsigned BYTE_SIZE_ROW         = ByteSizeRowDef,
  parameter int unsigned HEIGHT                = HeightDef,
  parameter logic [7:0]  STOP_BYTE             = StopByteDef,
  parameter logic [7:0]  ANSWER_CODE           = AnswerCodeDef,
  parameter logic [7:0]  SUCCESSFULLY_RECEIVED = SuccessDef,
  parameter logic [7:0]  NOT_ALL_RECEIVED      = NotAllDef,
  parameter int unsigned TIMEOUT_CYCLES        = TimeoutCyclesDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             wr_en,
  output logic [AddrW-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             row_done,
  output logic             frame_err,
  output logic             ans_ovf
);

  localparam int unsigned      IdxW      = $clog2(BYTE_SIZE_ROW + 1);
  localparam int unsigned      TimerW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(BYTE_SIZE_ROW - 1);
  localparam logic [IdxW-1:0]  IdxOne    = IdxW'(1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
  localparam logic [15:0]      HeightW   = 16'(HEIGHT);
  localparam logic [AddrW-1:0] RowSize   = AddrW'(BYTE_SIZE_ROW);

  state_e            state_q, state_d;
  logic [15:0]       row_q, row_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              wr_en_q, wr_en_d;
  logic [AddrW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              row_done_q, row_done_d;
  logic              err_q, err_d;
  logic              push;
  logic [7:0]        push_data;
  logic              timeout;
  logic [15:0]       row_lo;
  logic [AddrW-1:0]  row_base;

  // Next-state, frame-buffer write and answer selection; timeout beats a coincident byte.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    idx_d      = idx_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    row_done_d = 1'b0;
    err_d      = err_q;
    push       = 1'b0;
    push_data  = ANSWER_CODE;
    row_lo     = {row_q[15:8], rx_data};
    row_base   = AddrW'(row_q) * RowSize;
    timeout    = (state_q != StYHi) && (timer_q == TimerLast);

    if (state_q == StYHi || rx_done || timeout) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerOne;
    end

    if (timeout) begin
      state_d   = StYHi;
      push      = 1'b1;
      push_data = NOT_ALL_RECEIVED;
      err_d     = 1'b1;
    end else if (rx_done) begin
      unique case (state_q)
        StYHi: begin
          row_d   = {rx_data, row_q[7:0]};
          push    = 1'b1;
          state_d = StYLo;
        end
        StYLo: begin
          row_d = row_lo;
          push  = 1'b1;
          if (row_lo < HeightW) begin
            idx_d   = '0;
            state_d = StData;
          end else begin
            push_data = NOT_ALL_RECEIVED;
            err_d     = 1'b1;
            state_d   = StYHi;
          end
        end
        StData: begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_base + AddrW'(idx_q);
          wr_data_d = rx_data;
          push      = 1'b1;
          push_data = rx_data;
          idx_d     = idx_q + IdxOne;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end
        end
        StStop: begin
          push    = 1'b1;
          state_d = StYHi;
          if (rx_data == STOP_BYTE) begin
            push_data  = SUCCESSFULLY_RECEIVED;
            row_done_d = 1'b1;
          end else begin
            push_data = NOT_ALL_RECEIVED;
            err_d     = 1'b1;
          end
        end
        default: state_d = StYHi;
      endcase
    end
  end

  // Frame FSM, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StYHi;
      row_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      row_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      row_done_q <= row_done_d;
      err_q      <= err_d;
    end
  end

  uart_answer_queue u_answer_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .ovf       (ans_ovf)
  );

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign row_done  = row_done_q;
  assign frame_err = err_q;

endmodule

// File: doc/uart_row_loader.md
UART_ROW_LOADER -- requirements
Module: uart_row_loader

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- BYTE_SIZE_ROW, 240, payload bytes per row.
- HEIGHT, 480, number of valid rows.
- STOP_BYTE, 8'hDD, frame terminator.
- ANSWER_CODE, 8'hAA, acknowledge sent for each Y byte.
- SUCCESSFULLY_RECEIVED, 8'hFF, answer sent for a good frame.
- NOT_ALL_RECEIVED, 8'h11, answer sent for a bad or timed-out frame.
- TIMEOUT_CYCLES, 500_000, idle clocks between bytes before a frame is aborted.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning). It uses one clock; reset is synchronous and active-high.
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- rx_data, in, 8, byte from the UART receiver.
- rx_done, in, 1, one-clock strobe marking rx_data valid.
- tx_busy, in, 1, UART transmitter busy.
- tx_start, out, 1, one-clock transmit strobe.
- tx_data, out, 8, answer byte; held stable while tx_start is high.
- wr_en, out, 1, frame-buffer write strobe.
- wr_addr, out, 17, frame-buffer address, row*BYTE_SIZE_ROW+index.
- wr_data, out, 8, pixel byte.
- row_done, out, 1, one-clock pulse per good frame.
- frame_err, out, 1, sticky error flag, cleared only by rst.
- ans_ovf, out, 1, sticky answer-overflow flag, cleared only by rst.

Function
REQ-003 The FSM SHALL have the states Y_HI, Y_LO, DATA and STOP; every state advances only on rx_done.
REQ-004 In Y_HI the FSM SHALL latch rx_data as row[15:8], queue ANSWER_CODE, and go to Y_LO.
REQ-005 In Y_LO the FSM SHALL latch row[7:0] and queue ANSWER_CODE.
- If row < HEIGHT: clear idx and go to DATA.
- If row >= HEIGHT: set frame_err, queue NOT_ALL_RECEIVED instead of ANSWER_CODE, and go to Y_HI.
REQ-006 In DATA each byte SHALL be handled as follows:
- Drive wr_en=1, wr_addr=row*BYTE_SIZE_ROW+idx and wr_data=rx_data in the clock after rx_done (latency 1).
- Queue an echo of the byte.
- Increment idx; after byte BYTE_SIZE_ROW-1, go to STOP.
- A byte equal to STOP_BYTE is treated as data.
REQ-007 In STOP a byte equal to STOP_BYTE SHALL queue SUCCESSFULLY_RECEIVED, pulse row_done in the clock after rx_done, and go to Y_HI.
REQ-008 In STOP any other byte SHALL queue NOT_ALL_RECEIVED, set frame_err, produce no row_done, and go to Y_HI.
REQ-009 Timeout counter:
- Counts clocks in every state except Y_HI and restarts on each rx_done.
- On reaching TIMEOUT_CYCLES, the FSM SHALL queue NOT_ALL_RECEIVED, set frame_err and return to Y_HI.
- Bytes already written stay in the frame buffer.
REQ-010 The answer queue SHALL be a single-entry holding register.
- When the entry is full and tx_busy=0, assert tx_start for one clock with tx_data from the entry, then empty the entry.
- When a byte is queued while the entry is still full, overwrite the entry and set ans_ovf.
REQ-011 If a queue write and a transmit launch occur in the same clock, the new byte SHALL be stored and no overflow SHALL be flagged.
REQ-012 wr_addr SHALL be computed at 17-bit width with no wrap-around; the maximum is 479*240+239 = 115199.
REQ-013 An rx_done arriving in the same clock as a timeout SHALL be ignored, and the timeout SHALL take effect.

Reset
REQ-014 While rst=1 the block SHALL set the FSM to Y_HI, row=0, idx=0, the timer to 0 and the queue to empty.
REQ-015 While rst=1 all outputs SHALL be 0, including frame_err and ans_ovf.
REQ-016 A reset mid-frame SHALL drop the partial frame without sending any answer; the next byte is treated as Y_HI.

Structure
REQ-017 The answer codes, STOP_BYTE, BYTE_SIZE_ROW, HEIGHT and the FSM state enum SHALL be defined in the shared package uart2vga_pkg.
REQ-018 The answer queue SHALL be a sub-module named uart_answer_queue, with its own queue/launch handshake.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Good frame: Y=0x0005, 240 random bytes, then 0xDD -> answers AA, AA, 240 echoes, FF; wr_addr runs 1200..1439; exactly one row_done.
- Y out of range: Y=0x01E0 (480) -> answers AA, 11; frame_err=1; no wr_en; the next Y is accepted.
- Wrong terminator: full row ending in 0x00 instead of 0xDD -> answer 11; frame_err=1; no row_done.
- Timeout: Y=0x0000, 10 data bytes, then silence for TIMEOUT_CYCLES -> answer 11; FSM back in Y_HI; 10 writes at addresses 0..9.
- Answer overflow: hold tx_busy=1 across two queued bytes -> ans_ovf=1; after release, only the second byte is transmitted.
- Reset at data byte 100: no answer after reset; a following good frame for Y=479 ends with wr_addr=115199 and row_done.
